// File: rtl/regfile_scoreboard.sv
// NREG x XLEN register file (2 async reads, 1 sync write) with a per-register busy scoreboard.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [AW:0]     pending_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     cnt_next;
    logic            wb_en;
    logic            issue_en;

    assign wb_en    = wb_valid && (wb_rd != '0);
    assign issue_en = issue_valid && (issue_rd != '0);

    // Clear on writeback first, then set on issue so a same-edge new producer wins.
    always_comb begin
        busy_next = busy;
        if (wb_en)
            busy_next[wb_rd] = 1'b0;
        if (issue_en)
            busy_next[issue_rd] = 1'b1;
        if (flush)
            busy_next = '0;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 0; i < NREG; i++)
            cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_next;
            pending_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs1_busy = busy[rs1_addr];
        rs2_busy = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // Forwarded writeback clears busy unless the same rd is being re-issued this cycle.
        if (wb_en && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
            rs1_busy = issue_valid && (issue_rd == wb_rd);
        end
        if (wb_en && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
            rs2_busy = issue_valid && (issue_rd == wb_rd);
        end
`endif
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard, plus async-reset sequence.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [63:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, issue_valid, wb_valid, flush;
    logic [5:0]  pending_cnt;

    int tests;
    int fails;

    regfile_scoreboard #(.XLEN(64), .NREG(32)) dut (
        .clock(clock), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .pending_cnt(pending_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  r1, r2;
        logic        iv;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wrd;
        logic [63:0] wd;
        logic        fl;
        logic [63:0] e1, e2;
        logic        eb1, eb2;
        logic [5:0]  ec;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [4:0] r1, logic [4:0] r2, logic iv, logic [4:0] ird,
                                logic wv, logic [4:0] wrd, logic [63:0] wd, logic fl,
                                logic [63:0] e1, logic [63:0] e2, logic eb1, logic eb2,
                                logic [5:0] ec);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.iv = iv; v.ird = ird; v.wv = wv; v.wrd = wrd;
        v.wd = wd; v.fl = fl; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] e1, input logic [63:0] e2,
                             input logic eb1, input logic eb2, input logic [5:0] ec);
        check({tag, ".rs1_data"}, rs1_data, e1);
        check({tag, ".rs2_data"}, rs2_data, e2);
        check({tag, ".rs1_busy"}, {63'd0, rs1_busy}, {63'd0, eb1});
        check({tag, ".rs2_busy"}, {63'd0, rs2_busy}, {63'd0, eb2});
        check({tag, ".pending_cnt"}, {58'd0, pending_cnt}, {58'd0, ec});
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 0; rs1_addr = 0; rs2_addr = 0; idle();

        //          r1 r2 iv ird wv wrd wd              fl  e1              e2      eb1 eb2 cnt
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 64'd100,        0, 0,              0,          0, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 64'd200,        0, 0,              0,          0, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 1, 2, 64'd300,        0, 0,              64'd200,    0, 0, 0));
        vq.push_back(mk(1, 2, 0, 0, 0, 0, 0,              0, 64'd200,        64'd300,    0, 0, 0));
        vq.push_back(mk(5, 0, 1, 5, 0, 0, 0,              0, 0,              0,          0, 0, 0));
        vq.push_back(mk(5, 0, 0, 0, 0, 0, 0,              0, 0,              0,          1, 0, 1));
        vq.push_back(mk(1, 2, 0, 0, 1, 5, 64'hDEADBEEF,   0, 64'd200,        64'd300,    0, 0, 1));
        vq.push_back(mk(5, 0, 0, 0, 0, 0, 0,              0, 64'hDEADBEEF,   0,          0, 0, 0));
        vq.push_back(mk(1, 2, 1, 7, 1, 7, 64'd42,         0, 64'd200,        64'd300,    0, 0, 0));
        vq.push_back(mk(7, 0, 0, 0, 0, 0, 0,              0, 64'd42,         0,          1, 0, 1));
        vq.push_back(mk(7, 3, 1, 3, 0, 0, 0,              0, 64'd42,         0,          1, 0, 1));
        vq.push_back(mk(3, 4, 1, 4, 0, 0, 0,              0, 0,              0,          1, 0, 2));
        vq.push_back(mk(4, 6, 1, 6, 0, 0, 0,              0, 0,              0,          1, 0, 3));
        vq.push_back(mk(6, 7, 1, 9, 1, 3, 64'd9,          1, 0,              64'd42,     1, 1, 4));
        vq.push_back(mk(3, 9, 0, 0, 0, 0, 0,              0, 64'd9,          0,          0, 0, 0));
        vq.push_back(mk(7, 6, 0, 0, 0, 0, 0,              0, 64'd42,         0,          0, 0, 0));
        vq.push_back(mk(0, 0, 1, 10, 0, 0, 0,             0, 0,              0,          0, 0, 0));
        vq.push_back(mk(10, 0, 1, 10, 0, 0, 0,            0, 0,              0,          1, 0, 1));
        vq.push_back(mk(10, 0, 0, 0, 0, 0, 0,             0, 0,              0,          1, 0, 1));
        vq.push_back(mk(10, 1, 0, 0, 1, 11, 64'd55,       0, 0,              64'd200,    1, 0, 1));
        vq.push_back(mk(11, 10, 0, 0, 0, 0, 0,            0, 64'd55,         0,          0, 1, 1));
        vq.push_back(mk(1, 8, 0, 0, 1, 8, 64'h1234,       0, 64'd200,        BYP ? 64'h1234 : 64'd0, 0, 0, 1));
        vq.push_back(mk(8, 11, 0, 0, 0, 0, 0,             0, 64'h1234,       64'd55,     0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 1, 10, 64'd77,        0, 0,              0,          0, 0, 1));
        vq.push_back(mk(10, 0, 0, 0, 0, 0, 0,             0, 64'd77,         0,          0, 0, 0));

        #3;
        rs1_addr = 1; rs2_addr = 2;
        check_all("in_reset", 0, 0, 0, 0, 0);
        #9 reset = 1;
        #1 check_all("after_reset", 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clock);
            rs1_addr = vq[i].r1; rs2_addr = vq[i].r2;
            issue_valid = vq[i].iv; issue_rd = vq[i].ird;
            wb_valid = vq[i].wv; wb_rd = vq[i].wrd; wb_data = vq[i].wd; flush = vq[i].fl;
            #1 check_all($sformatf("vec%0d", i), vq[i].e1, vq[i].e2, vq[i].eb1, vq[i].eb2, vq[i].ec);
        end

        // Load some busy state, then pull reset between edges.
        @(negedge clock); idle(); issue_valid = 1; issue_rd = 12;
        @(negedge clock); idle(); rs1_addr = 12; rs2_addr = 7;
        #1 check_all("pre_async", 0, 64'd42, 1, 0, 1);
        #1 reset = 0; issue_valid = 1; issue_rd = 13;
        #1 rs1_addr = 1; rs2_addr = 12;
        #1 check_all("async_reset", 0, 0, 0, 0, 0);
        @(posedge clock);
        #2 rs1_addr = 7; rs2_addr = 13;
        #1 check_all("reset_held", 0, 0, 0, 0, 0);
        @(negedge clock); reset = 1; idle();
        @(negedge clock);
        #1 check_all("post_reset", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
